// File: rtl/hist_stat_pkg.sv
// hist_stat_pkg
//   Shared definitions for the histogram accumulation stage: default bin
//   address/count widths, bin geometry, FSM state encoding and the kinds of
//   operation that travel down the read-modify-write pipeline.
package hist_stat_pkg;

  localparam int DEF_AW  = 8;
  localparam int DEF_DW  = 14;
  localparam int NBINS   = 1 << DEF_AW;
  localparam int BIN_MAX = (1 << DEF_DW) - 1;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_DUMP
  } state_e;

  // OP_INC: count a pixel, OP_ZERO: power-up clear, OP_DUMP: read-out + clear
  typedef enum logic [1:0] {
    OP_INC,
    OP_ZERO,
    OP_DUMP
  } op_e;

endpackage

// File: rtl/hist_rmw_pipe.sv
// hist_rmw_pipe
//   Stage 1 of the histogram read-modify-write pipeline. An operation issued
//   in cycle t (with its RAM read launched by the caller in the same cycle)
//   is registered here and, in cycle t+1, produces the RAM write-port drive.
//   Pixel increments saturate at the all-ones count; zero and dump
//   operations write 0. The value seen as "old" comes from the previous
//   cycle's write when it hit the same bin, because the RAM returns the
//   pre-write value for a read and write to one address on the same edge.
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   issue_i, op_i, addr_i   operation issued this cycle
//   ram_qa_i                RAM read data for the stage-1 address
//   s1_vld_o/op_o/addr_o    stage-1 contents, for output formatting
//   old_o                   bin value before this operation (forwarded)
//   ram_ab_o/db_o/cenb_o    RAM write port, enable active-low
module hist_rmw_pipe
  import hist_stat_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          issue_i,
  input  logic [1:0]    op_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] ram_qa_i,
  output logic          s1_vld_o,
  output logic [1:0]    s1_op_o,
  output logic [AW-1:0] s1_addr_o,
  output logic [DW-1:0] old_o,
  output logic [AW-1:0] ram_ab_o,
  output logic [DW-1:0] ram_db_o,
  output logic          ram_cenb_o
);

  localparam logic [DW-1:0] SAT_MAX = {DW{1'b1}};

  logic          s1Vld_q;
  logic [1:0]    s1Op_q;
  logic [AW-1:0] s1Addr_q;
  logic          prvVld_q;
  logic [AW-1:0] prvAddr_q;
  logic [DW-1:0] prvData_q;

  logic          fwdHit;
  logic [DW-1:0] oldVal;
  logic [DW-1:0] newVal;
  logic [DW-1:0] wrData;

  // Stage-1 registers plus a copy of the write retired last cycle, which is
  // what the forwarding compare looks at.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1Vld_q   <= 1'b0;
      s1Op_q    <= OP_INC;
      s1Addr_q  <= '0;
      prvVld_q  <= 1'b0;
      prvAddr_q <= '0;
      prvData_q <= '0;
    end else begin
      s1Vld_q   <= issue_i;
      s1Op_q    <= op_i;
      s1Addr_q  <= addr_i;
      prvVld_q  <= s1Vld_q;
      prvAddr_q <= s1Addr_q;
      prvData_q <= wrData;
    end
  end

  // Forwarding select, saturating increment and write data.
  always_comb begin
    fwdHit = prvVld_q && (prvAddr_q == s1Addr_q);
    oldVal = fwdHit ? prvData_q : ram_qa_i;
    newVal = (oldVal == SAT_MAX) ? oldVal : oldVal + 1'b1;
    wrData = (s1Op_q == OP_INC) ? newVal : '0;
  end

  assign s1_vld_o   = s1Vld_q;
  assign s1_op_o    = s1Op_q;
  assign s1_addr_o  = s1Addr_q;
  assign old_o      = oldVal;
  assign ram_ab_o   = s1Addr_q;
  assign ram_db_o   = s1Vld_q ? wrData : '0;
  assign ram_cenb_o = ~s1Vld_q;

endmodule

// File: rtl/hist_stat.sv
// hist_stat
//   Histogram accumulation stage. Counts one frame of pixel values into an
//   external 256-bin two-port RAM, then streams every bin count downstream
//   while clearing it, so the RAM is ready for the next frame.
//   After reset the whole RAM is cleared once (INIT).
// Ports
//   CLK, RST                        clock, synchronous active-high reset
//   FRAME_START, FRAME_END          one-cycle frame delimiters
//   PIX_VLD, PIX_DATA               pixel stream, PIX_DATA is the bin index
//   BUSY                            high while clearing, draining or dumping
//   HIST_VLD/BIN/CNT/LAST           bin read-out stream, LAST on bin 255
//   RAM_AA, RAM_CENA, RAM_QA        RAM read port (active-low enable)
//   RAM_AB, RAM_DB, RAM_CENB        RAM write port (active-low enable)
module hist_stat
  import hist_stat_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          FRAME_START,
  input  logic          FRAME_END,
  input  logic          PIX_VLD,
  input  logic [AW-1:0] PIX_DATA,
  output logic          BUSY,
  output logic          HIST_VLD,
  output logic [AW-1:0] HIST_BIN,
  output logic [DW-1:0] HIST_CNT,
  output logic          HIST_LAST,
  output logic [AW-1:0] RAM_AA,
  output logic          RAM_CENA,
  input  logic [DW-1:0] RAM_QA,
  output logic [AW-1:0] RAM_AB,
  output logic [DW-1:0] RAM_DB,
  output logic          RAM_CENB
);

  // The sweep counter is one bit wider than a bin address so DUMP can
  // count its trailing output cycle after the 256 read issues.
  localparam logic [AW:0] CNT_LAST_BIN = (AW+1)'((1 << AW) - 1);
  localparam logic [AW:0] CNT_TRAIL    = (AW+1)'(1 << AW);

  state_e        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;

  logic          issue;
  logic [1:0]    issueOp;
  logic [AW-1:0] issueAddr;

  logic          s1Vld;
  logic [1:0]    s1Op;
  logic [AW-1:0] s1Addr;
  logic [DW-1:0] oldVal;
  logic          dumpOut;

  // State and sweep-counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, read-port drive and the operation handed to the pipeline.
  // INIT and DUMP walk the bins with cnt_q; ACCUM forwards pixels.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    issue     = 1'b0;
    issueOp   = OP_INC;
    issueAddr = '0;
    RAM_AA    = '0;
    RAM_CENA  = 1'b1;
    BUSY      = 1'b1;
    case (state_q)
      ST_INIT: begin
        issue     = 1'b1;
        issueOp   = OP_ZERO;
        issueAddr = cnt_q[AW-1:0];
        if (cnt_q == CNT_LAST_BIN) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        BUSY = 1'b0;
        if (FRAME_START) begin
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        BUSY = 1'b0;
        if (PIX_VLD) begin
          issue     = 1'b1;
          issueOp   = OP_INC;
          issueAddr = PIX_DATA;
          RAM_AA    = PIX_DATA;
          RAM_CENA  = 1'b0;
        end
        if (FRAME_END) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_DUMP;
        cnt_d   = '0;
      end
      ST_DUMP: begin
        if (cnt_q == CNT_TRAIL) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          issue     = 1'b1;
          issueOp   = OP_DUMP;
          issueAddr = cnt_q[AW-1:0];
          RAM_AA    = cnt_q[AW-1:0];
          RAM_CENA  = 1'b0;
          cnt_d     = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  hist_rmw_pipe #(
    .AW(AW),
    .DW(DW)
  ) u_pipe (
    .clk_i      (CLK),
    .rst_i      (RST),
    .issue_i    (issue),
    .op_i       (issueOp),
    .addr_i     (issueAddr),
    .ram_qa_i   (RAM_QA),
    .s1_vld_o   (s1Vld),
    .s1_op_o    (s1Op),
    .s1_addr_o  (s1Addr),
    .old_o      (oldVal),
    .ram_ab_o   (RAM_AB),
    .ram_db_o   (RAM_DB),
    .ram_cenb_o (RAM_CENB)
  );

  // A dump entry in stage 1 is the read-out cycle for that bin; its clear
  // write goes out on the RAM write port in the same cycle.
  assign dumpOut   = s1Vld && (s1Op == OP_DUMP);
  assign HIST_VLD  = dumpOut;
  assign HIST_BIN  = dumpOut ? s1Addr : '0;
  assign HIST_CNT  = dumpOut ? oldVal : '0;
  assign HIST_LAST = dumpOut && (s1Addr == '1);

endmodule
